// File: rtl/mriscv_pkg.sv
// Shared definitions for the memory stage: load/store width codes and the
// memory-access FSM state type.
package mriscv_pkg;

  // Load width/sign codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store width codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    StIdle,
    StReq
  } mem_state_t;

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic for the memory stage.
//   Request side : i_is_load/i_is_store/i_func3/i_addr_lo/i_store_data ->
//                  o_wdata (lane-replicated store data), o_wstrb (byte enables),
//                  o_fault (illegal func3 or misaligned access).
//   Response side: i_ld_func3/i_ld_addr_lo/i_rdata -> o_ld_data (extracted and
//                  sign/zero-extended load value).
module lsu_lane
  import mriscv_pkg::*;
(
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_fault,
  input  logic [2:0]  i_ld_func3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic        w_legal;
  logic        w_misaligned;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_legal = 1'b0;
    if (i_is_load) begin
      case (i_func3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: w_legal = 1'b1;
        default:                             w_legal = 1'b0;
      endcase
    end else if (i_is_store) begin
      case (i_func3)
        F3_SB, F3_SH, F3_SW: w_legal = 1'b1;
        default:             w_legal = 1'b0;
      endcase
    end
  end

  // func3[1:0] encodes the access size for every legal code
  assign w_misaligned = ((i_func3[1:0] == 2'b01) && i_addr_lo[0]) ||
                        ((i_func3[1:0] == 2'b10) && (i_addr_lo != 2'b00));

  assign o_fault = (i_is_load || i_is_store) && (!w_legal || w_misaligned);

  always_comb begin
    o_wdata = i_store_data;
    o_wstrb = 4'b0000;
    if (i_is_store) begin
      case (i_func3)
        F3_SB: begin
          o_wstrb = 4'b0001 << i_addr_lo;
          o_wdata = {4{i_store_data[7:0]}};
        end
        F3_SH: begin
          o_wstrb = 4'b0011 << i_addr_lo;
          o_wdata = {2{i_store_data[15:0]}};
        end
        F3_SW:   o_wstrb = 4'b1111;
        default: o_wstrb = 4'b0000;
      endcase
    end
  end

  assign w_byte = 8'(i_rdata >> {i_ld_addr_lo, 3'b000});
  assign w_half = 16'(i_rdata >> {i_ld_addr_lo[1], 4'b0000});

  always_comb begin
    case (i_ld_func3)
      F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_ld_data = {24'h00_0000, w_byte};
      F3_LHU:  o_ld_data = {16'h0000, w_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory/writeback stage. Accepts one operation per valid_i/ready_o handshake,
// runs a single-outstanding bus transaction for loads and stores, and emits a
// one-cycle writeback strobe (wb_valid/wb_dest/wb_data) after completion.
//   Upstream : valid_i, ready_o, is_load, is_store, result, store_data, func3, dest_i
//   Bus      : mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, mem_rdata, mem_ack
//   Writeback: wb_valid, wb_dest, wb_data, exc_misaligned, exc_bus
module memory_access
  import mriscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] result,
  input  logic [31:0] store_data,
  input  logic [2:0]  func3,
  input  logic [4:0]  dest_i,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        exc_misaligned,
  output logic        exc_bus
);

  // Last no-ack REQ cycle before the transaction is abandoned
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  mem_state_t  r_state,   w_state_nxt;
  logic [7:0]  r_cnt,     w_cnt_nxt;
  logic        r_we,      w_we_nxt;
  logic [31:0] r_addr,    w_addr_nxt;
  logic [31:0] r_wdata,   w_wdata_nxt;
  logic [3:0]  r_wstrb,   w_wstrb_nxt;
  logic [2:0]  r_ld_f3,   w_ld_f3_nxt;
  logic [1:0]  r_ld_alo,  w_ld_alo_nxt;
  logic [4:0]  r_dest,    w_dest_nxt;
  logic        r_wb_vld,  w_wb_vld_nxt;
  logic [4:0]  r_wb_dest, w_wb_dest_nxt;
  logic [31:0] r_wb_data, w_wb_data_nxt;
  logic        r_exc_mis, w_exc_mis_nxt;
  logic        r_exc_bus, w_exc_bus_nxt;

  logic [31:0] w_lane_wdata;
  logic [3:0]  w_lane_wstrb;
  logic        w_fault;
  logic [31:0] w_ld_data;

  lsu_lane u_lane (
    .i_is_load    (is_load),
    .i_is_store   (is_store),
    .i_func3      (func3),
    .i_addr_lo    (result[1:0]),
    .i_store_data (store_data),
    .o_wdata      (w_lane_wdata),
    .o_wstrb      (w_lane_wstrb),
    .o_fault      (w_fault),
    .i_ld_func3   (r_ld_f3),
    .i_ld_addr_lo (r_ld_alo),
    .i_rdata      (mem_rdata),
    .o_ld_data    (w_ld_data)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_we_nxt      = r_we;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_wstrb_nxt   = r_wstrb;
    w_ld_f3_nxt   = r_ld_f3;
    w_ld_alo_nxt  = r_ld_alo;
    w_dest_nxt    = r_dest;
    w_wb_vld_nxt  = 1'b0;
    w_wb_dest_nxt = r_wb_dest;
    w_wb_data_nxt = r_wb_data;
    w_exc_mis_nxt = 1'b0;
    w_exc_bus_nxt = 1'b0;
    case (r_state)
      StIdle: begin
        if (valid_i) begin
          if (!is_load && !is_store) begin
            w_wb_vld_nxt  = 1'b1;
            w_wb_dest_nxt = dest_i;
            w_wb_data_nxt = result;
          end else if (w_fault) begin
            w_exc_mis_nxt = 1'b1;
            w_wb_vld_nxt  = 1'b1;
            w_wb_dest_nxt = 5'd0;
          end else begin
            w_state_nxt  = StReq;
            w_cnt_nxt    = 8'd0;
            w_we_nxt     = is_store;
            w_addr_nxt   = {result[31:2], 2'b00};
            w_wdata_nxt  = w_lane_wdata;
            w_wstrb_nxt  = w_lane_wstrb;
            w_ld_f3_nxt  = func3;
            w_ld_alo_nxt = result[1:0];
            w_dest_nxt   = is_store ? 5'd0 : dest_i;
          end
        end
      end
      StReq: begin
        // An ack on the timeout cycle still completes the transaction
        if (mem_ack) begin
          w_state_nxt   = StIdle;
          w_wb_vld_nxt  = 1'b1;
          w_wb_dest_nxt = r_dest;
          if (!r_we) begin
            w_wb_data_nxt = w_ld_data;
          end
        end else if (r_cnt == CntLast) begin
          w_state_nxt   = StIdle;
          w_exc_bus_nxt = 1'b1;
          w_wb_vld_nxt  = 1'b1;
          w_wb_dest_nxt = 5'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_cnt     <= 8'd0;
      r_we      <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_wstrb   <= 4'd0;
      r_ld_f3   <= 3'd0;
      r_ld_alo  <= 2'd0;
      r_dest    <= 5'd0;
      r_wb_vld  <= 1'b0;
      r_wb_dest <= 5'd0;
      r_wb_data <= 32'd0;
      r_exc_mis <= 1'b0;
      r_exc_bus <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wstrb   <= w_wstrb_nxt;
      r_ld_f3   <= w_ld_f3_nxt;
      r_ld_alo  <= w_ld_alo_nxt;
      r_dest    <= w_dest_nxt;
      r_wb_vld  <= w_wb_vld_nxt;
      r_wb_dest <= w_wb_dest_nxt;
      r_wb_data <= w_wb_data_nxt;
      r_exc_mis <= w_exc_mis_nxt;
      r_exc_bus <= w_exc_bus_nxt;
    end
  end

  assign ready_o        = (r_state == StIdle);
  assign mem_req        = (r_state == StReq);
  assign mem_we         = r_we;
  assign mem_addr       = r_addr;
  assign mem_wdata      = r_wdata;
  assign mem_wstrb      = r_wstrb;
  assign wb_valid       = r_wb_vld;
  assign wb_dest        = r_wb_dest;
  assign wb_data        = r_wb_data;
  assign exc_misaligned = r_exc_mis;
  assign exc_bus        = r_exc_bus;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: a transaction-level model predicts the per-cycle
// outputs of each directed operation into a queue; one negedge process
// compares the DUT against it. Literal checks pin key results.
module tb_memory_access;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, is_load, is_store, mem_ack;
  logic [31:0] result, store_data, mem_rdata;
  logic [2:0]  func3;
  logic [4:0]  dest_i;
  logic        ready_o, mem_req, mem_we, wb_valid, exc_misaligned, exc_bus;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_wstrb;
  logic [4:0]  wb_dest;

  memory_access #(.TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .is_load        (is_load),
    .is_store       (is_store),
    .result         (result),
    .store_data     (store_data),
    .func3          (func3),
    .dest_i         (dest_i),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .wb_valid       (wb_valid),
    .wb_dest        (wb_dest),
    .wb_data        (wb_data),
    .exc_misaligned (exc_misaligned),
    .exc_bus        (exc_bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        chk_data;
    logic        exc_mis;
    logic        exc_bus;
  } exp_t;

  exp_t exp_q[$];
  exp_t ce;
  int   n_pass = 0;
  int   n_total = 0;

  // Model state: pending writeback for the next cycle, held wb values, bus view
  logic        p_valid = 0, p_has_data = 0, p_mis = 0, p_bus = 0;
  logic [4:0]  p_dest = 0;
  logic [31:0] p_data = 0;
  logic [4:0]  m_dest = 0;
  logic [31:0] m_data = 0;
  logic        m_known = 1;
  logic        b_we = 0;
  logic [31:0] b_addr = 0, b_wdata = 0;
  logic [3:0]  b_wstrb = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
  endtask

  function automatic void st_lanes(input logic [2:0] f3, input logic [1:0] a,
                                   input logic [31:0] sd, output logic [31:0] wd,
                                   output logic [3:0] ws);
    int sz;
    sz = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) begin
      wd[8*i+:8] = sd[8*(i%sz)+:8];
      ws[i] = (i >= int'(a)) && (i < int'(a) + sz);
    end
  endfunction

  function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] rd);
    int sz;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    v = 32'd0;
    for (int i = 0; i < sz; i++) v[8*i+:8] = rd[8*(int'(a)+i)+:8];
    if (!f3[2] && sz < 4 && v[8*sz-1])
      for (int i = sz; i < 4; i++) v[8*i+:8] = 8'hFF;
    return v;
  endfunction

  function automatic logic is_fault(input logic st, input logic [2:0] f3, input logic [1:0] a);
    int sz;
    if (f3[1:0] == 2'b11) return 1'b1;
    if (f3[2] && (st || f3[1:0] == 2'b10)) return 1'b1;
    sz = 1 << f3[1:0];
    return (int'(a) % sz) != 0;
  endfunction

  task automatic make(input logic rdy, input logic req, output exp_t e);
    e = '0;
    e.ready = rdy;
    e.req   = req;
    e.we    = b_we;
    e.addr  = b_addr;
    e.wdata = b_wdata;
    e.wstrb = b_wstrb;
    if (p_valid) begin
      e.wb_valid = 1'b1;
      e.exc_mis  = p_mis;
      e.exc_bus  = p_bus;
      m_dest     = p_dest;
      if (p_has_data) begin
        m_data  = p_data;
        m_known = 1'b1;
      end else begin
        m_known = 1'b0;
      end
      p_valid = 1'b0;
    end
    e.wb_dest  = m_dest;
    e.wb_data  = m_data;
    e.chk_data = m_known;
  endtask

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      make(1'b1, 1'b0, e);
      step(e);
    end
  endtask

  task automatic set_pend(input logic [4:0] d, input logic [31:0] v, input logic hd,
                          input logic mis, input logic bus);
    p_valid = 1'b1; p_dest = d; p_data = v; p_has_data = hd; p_mis = mis; p_bus = bus;
  endtask

  task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] res, input logic [31:0] sd,
                         input logic [4:0] dest, input logic [31:0] rdata);
    valid_i = 1'b1; is_load = ld; is_store = st; func3 = f3;
    result = res; store_data = sd; dest_i = dest; mem_rdata = rdata;
  endtask

  task automatic set_bus(input logic st, input logic [2:0] f3, input logic [31:0] res,
                         input logic [31:0] sd);
    b_we   = st;
    b_addr = {res[31:2], 2'b00};
    st_lanes(f3, res[1:0], sd, b_wdata, b_wstrb);
    if (!st) b_wstrb = 4'b0000;
  endtask

  // delay: REQ cycles before ack (0 = ack in first REQ cycle); negative = never
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] res, input logic [31:0] sd,
                        input logic [4:0] dest, input logic [31:0] rdata, input int delay);
    exp_t e;
    present(ld, st, f3, res, sd, dest, rdata);
    make(1'b1, 1'b0, e);
    step(e);
    if (!ld && !st) begin
      set_pend(dest, res, 1'b1, 1'b0, 1'b0);
      return;
    end
    if (is_fault(st, f3, res[1:0])) begin
      set_pend(5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      return;
    end
    set_bus(st, f3, res, sd);
    for (int k = 0; k < T; k++) begin
      mem_ack = (k == delay);
      make(1'b0, 1'b1, e);
      step(e);
      if (k == delay) begin
        set_pend(ld ? dest : 5'd0, ld_val(f3, res[1:0], rdata), ld, 1'b0, 1'b0);
        return;
      end
    end
    set_pend(5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      chk("ready_o", ready_o, ce.ready);
      chk("mem_req", mem_req, ce.req);
      if (ce.req) begin
        chk("mem_we", mem_we, ce.we);
        chk("mem_addr", mem_addr, ce.addr);
        chk("mem_wstrb", mem_wstrb, ce.wstrb);
        if (ce.we) chk("mem_wdata", mem_wdata, ce.wdata);
      end
      chk("wb_valid", wb_valid, ce.wb_valid);
      chk("exc_misaligned", exc_misaligned, ce.exc_mis);
      chk("exc_bus", exc_bus, ce.exc_bus);
      chk("wb_dest", wb_dest, ce.wb_dest);
      if (ce.chk_data) chk("wb_data", wb_data, ce.wb_data);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_ready_o"}, ready_o, 1);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_wb_dest"}, wb_dest, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
    chk({tag, "_exc"}, {exc_misaligned, exc_bus}, 0);
  endtask

  initial begin
    exp_t e;
    reset = 1'b0;
    present(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 32'd0);
    valid_i = 1'b0;
    mem_ack = 1'b0;
    #3;
    chk_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(1);

    // lb at 0x203, ack on the 4th REQ cycle
    run_op(1, 0, 3'b000, 32'h0000_0203, 32'h0, 5'd7, 32'h80FF_0000, 3);
    chk("lb_wb_valid", wb_valid, 1);
    chk("lb_wb_dest", wb_dest, 7);
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
    // lhu at 0x12, immediate ack (back-to-back with the lb writeback)
    run_op(1, 0, 3'b101, 32'h0000_0012, 32'h0, 5'd3, 32'hBEEF_1234, 0);
    chk("lhu_wb_data", wb_data, 32'h0000_BEEF);
    // sh at 0x12
    run_op(0, 1, 3'b001, 32'h0000_0012, 32'hAAAA_5678, 5'd5, 32'h0, 1);
    chk("sh_wb_valid", wb_valid, 1);
    chk("sh_wb_dest", wb_dest, 0);
    idle(1);
    // Further lane patterns
    run_op(0, 1, 3'b000, 32'h0000_0401, 32'h1234_56CD, 5'd4, 32'h0, 2);
    run_op(0, 1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 5'd4, 32'h0, 0);
    run_op(1, 0, 3'b001, 32'h0000_0006, 32'h0, 5'd11, 32'h9ABC_0011, 1);
    run_op(1, 0, 3'b100, 32'h0000_0081, 32'h0, 5'd12, 32'h0000_F000, 0);
    run_op(1, 0, 3'b010, 32'h0000_0084, 32'h0, 5'd13, 32'hCAFE_F00D, 2);
    run_op(1, 0, 3'b000, 32'h0000_0080, 32'h0, 5'd14, 32'h0000_007F, 0);
    idle(1);

    // Misaligned lw and illegal func3
    run_op(1, 0, 3'b010, 32'h0000_0102, 32'h0, 5'd6, 32'h0, 0);
    chk("lw_mis_exc", exc_misaligned, 1);
    chk("lw_mis_dest", wb_dest, 0);
    chk("lw_mis_req", mem_req, 0);
    run_op(1, 0, 3'b011, 32'h0000_0100, 32'h0, 5'd6, 32'h0, 0);
    chk("f3_011_exc", exc_misaligned, 1);
    chk("f3_011_dest", wb_dest, 0);
    run_op(0, 1, 3'b001, 32'h0000_0013, 32'h0, 5'd6, 32'h0, 0);
    run_op(0, 1, 3'b100, 32'h0000_0010, 32'h0, 5'd6, 32'h0, 0);
    run_op(1, 0, 3'b110, 32'h0000_0010, 32'h0, 5'd6, 32'h0, 0);
    idle(1);

    // Back-to-back ALU ops
    run_op(0, 0, 3'b000, 32'hFFFF_FF9C, 32'h0, 5'd9, 32'h0, 0);
    chk("alu_wb_data", wb_data, 32'hFFFF_FF9C);
    chk("alu_wb_dest", wb_dest, 9);
    run_op(0, 0, 3'b010, 32'h0000_0055, 32'h0, 5'd2, 32'h0, 0);
    chk("alu2_wb_data", wb_data, 32'h0000_0055);
    idle(1);

    // Ack while idle is ignored
    mem_ack = 1'b1;
    mem_rdata = 32'h1111_2222;
    idle(3);

    // sw with no ack times out after T cycles
    run_op(0, 1, 3'b010, 32'h0000_0080, 32'h0BAD_F00D, 5'd8, 32'h0, -1);
    chk("to_exc_bus", exc_bus, 1);
    chk("to_wb_dest", wb_dest, 0);
    chk("to_ready", ready_o, 1);
    idle(1);
    // Ack on the timeout cycle completes normally
    run_op(1, 0, 3'b010, 32'h0000_0088, 32'h0, 5'd10, 32'h7654_3210, T - 1);
    chk("to_ack_exc_bus", exc_bus, 0);
    chk("to_ack_wb_data", wb_data, 32'h7654_3210);
    idle(2);

    // Reset during an outstanding load at 0x100
    present(1, 0, 3'b010, 32'h0000_0100, 32'h0, 5'd15, 32'h5555_AAAA);
    make(1'b1, 1'b0, e);
    step(e);
    set_bus(1'b0, 3'b010, 32'h0000_0100, 32'h0);
    for (int k = 0; k < 2; k++) begin
      make(1'b0, 1'b1, e);
      step(e);
    end
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("rst_req");
    @(posedge clk);
    #1;
    chk("rst_hold_req", mem_req, 0);
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    p_valid = 1'b0;
    m_dest  = 5'd0;
    m_data  = 32'd0;
    m_known = 1'b1;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
